// File: rtl/controle_elevador_chamadas_pkg.sv
// Shared definitions for the elevator controller: FSM states, direction
// encoding and default timing.
package pkg_elevador;

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    MOVENDO = 2'd1,
    PORTA   = 2'd2
  } estado_t;

  localparam logic SOBE  = 1'b1;
  localparam logic DESCE = 1'b0;

  localparam int unsigned N_ANDARES_PADRAO = 4;
  localparam int unsigned T_VIAGEM_PADRAO  = 2;
  localparam int unsigned T_PORTA_PADRAO   = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/controle_elevador_chamadas_busca_chamadas.sv
// Combinational call search: flags pending calls above, below and at a floor.
module busca_chamadas #(
  parameter int unsigned N_ANDARES = 4,
  parameter int unsigned W_ANDAR   = $clog2(N_ANDARES)
) (
  input  logic [N_ANDARES-1:0] pendentes,
  input  logic [W_ANDAR-1:0]   andar,
  output logic                 acima,
  output logic                 abaixo,
  output logic                 aqui
);

  // Scan every floor and classify it relative to the reference floor
  always_comb begin
    acima  = 1'b0;
    abaixo = 1'b0;
    aqui   = 1'b0;
    for (int unsigned i = 0; i < N_ANDARES; i++) begin
      if (i > 32'(andar)) begin
        acima = acima | pendentes[i];
      end else if (i < 32'(andar)) begin
        abaixo = abaixo | pendentes[i];
      end else begin
        aqui = pendentes[i];
      end
    end
  end

endmodule

// File: rtl/controle_elevador_chamadas.sv
// SCAN elevator controller: latches floor calls, steps between floors and
// holds the door open, all timed in units of the external tick enable.
module controle_elevador_chamadas
  import pkg_elevador::*;
#(
  parameter int unsigned N_ANDARES = N_ANDARES_PADRAO,
  parameter int unsigned W_ANDAR   = $clog2(N_ANDARES),
  parameter int unsigned T_VIAGEM  = T_VIAGEM_PADRAO,
  parameter int unsigned T_PORTA   = T_PORTA_PADRAO
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic [N_ANDARES-1:0] chamada,
  output logic [W_ANDAR-1:0]   andar_atual,
  output logic                 subindo,
  output logic                 descendo,
  output logic                 porta_aberta,
  output logic [N_ANDARES-1:0] pendentes
);

  localparam int unsigned W_CNT = $clog2(max_u(T_VIAGEM, T_PORTA) + 1);

  estado_t              estado_q, estado_d;
  logic                 dir_q, dir_d;
  logic [W_ANDAR-1:0]   andar_q, andar_d;
  logic [W_CNT-1:0]     cnt_viagem_q, cnt_viagem_d;
  logic [W_CNT-1:0]     cnt_porta_q, cnt_porta_d;
  logic [N_ANDARES-1:0] pend_q;
  logic [N_ANDARES-1:0] limpa;
  logic [W_ANDAR-1:0]   andar_viz;

  logic acima, abaixo, aqui;
  logic acima_v, abaixo_v, aqui_v;
  logic adiante, atras, adiante_v;

  // Floor reached by the next step in the current direction, clamped at the ends
  always_comb begin
    andar_viz = andar_q;
    if (dir_q == SOBE) begin
      if (andar_q != W_ANDAR'(N_ANDARES - 1)) andar_viz = andar_q + W_ANDAR'(1);
    end else begin
      if (andar_q != '0) andar_viz = andar_q - W_ANDAR'(1);
    end
  end

  busca_chamadas #(
    .N_ANDARES (N_ANDARES),
    .W_ANDAR   (W_ANDAR)
  ) u_busca_atual (
    .pendentes (pend_q),
    .andar     (andar_q),
    .acima     (acima),
    .abaixo    (abaixo),
    .aqui      (aqui)
  );

  // Same search seen from the floor about to be entered, so the arrival
  // decision uses the new floor without an extra cycle
  busca_chamadas #(
    .N_ANDARES (N_ANDARES),
    .W_ANDAR   (W_ANDAR)
  ) u_busca_vizinho (
    .pendentes (pend_q),
    .andar     (andar_viz),
    .acima     (acima_v),
    .abaixo    (abaixo_v),
    .aqui      (aqui_v)
  );

  assign adiante   = (dir_q == SOBE) ? acima   : abaixo;
  assign atras     = (dir_q == SOBE) ? abaixo  : acima;
  assign adiante_v = (dir_q == SOBE) ? acima_v : abaixo_v;

  // Next-state, counters, floor step and call-clear mask; only ticks advance
  always_comb begin
    estado_d     = estado_q;
    dir_d        = dir_q;
    andar_d      = andar_q;
    cnt_viagem_d = cnt_viagem_q;
    cnt_porta_d  = cnt_porta_q;
    limpa        = '0;
    if (tick) begin
      case (estado_q)
        PARADO: begin
          if (aqui) begin
            estado_d       = PORTA;
            limpa[andar_q] = 1'b1;
            cnt_porta_d    = W_CNT'(T_PORTA);
          end else if (acima) begin
            dir_d        = SOBE;
            estado_d     = MOVENDO;
            cnt_viagem_d = W_CNT'(T_VIAGEM);
          end else if (abaixo) begin
            dir_d        = DESCE;
            estado_d     = MOVENDO;
            cnt_viagem_d = W_CNT'(T_VIAGEM);
          end
        end
        MOVENDO: begin
          // The tick that takes the counter to zero is the arrival tick
          if (cnt_viagem_q > W_CNT'(1)) begin
            cnt_viagem_d = cnt_viagem_q - W_CNT'(1);
          end else begin
            andar_d = andar_viz;
            if (aqui_v) begin
              estado_d         = PORTA;
              limpa[andar_viz] = 1'b1;
              cnt_porta_d      = W_CNT'(T_PORTA);
              cnt_viagem_d     = '0;
            end else if (adiante_v) begin
              cnt_viagem_d = W_CNT'(T_VIAGEM);
            end else begin
              estado_d     = PARADO;
              cnt_viagem_d = '0;
            end
          end
        end
        PORTA: begin
          // A call at this floor while open keeps the door open
          if (aqui || chamada[andar_q]) begin
            limpa[andar_q] = 1'b1;
            cnt_porta_d    = W_CNT'(T_PORTA);
          end else if (cnt_porta_q > W_CNT'(1)) begin
            cnt_porta_d = cnt_porta_q - W_CNT'(1);
          end else begin
            cnt_porta_d = '0;
            if (adiante) begin
              estado_d     = MOVENDO;
              cnt_viagem_d = W_CNT'(T_VIAGEM);
            end else if (atras) begin
              dir_d        = ~dir_q;
              estado_d     = MOVENDO;
              cnt_viagem_d = W_CNT'(T_VIAGEM);
            end else begin
              estado_d = PARADO;
            end
          end
        end
        default: begin
          estado_d = PARADO;
        end
      endcase
    end
  end

  // State, direction, floor and timer registers
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= PARADO;
      dir_q        <= SOBE;
      andar_q      <= '0;
      cnt_viagem_q <= '0;
      cnt_porta_q  <= '0;
    end else begin
      estado_q     <= estado_d;
      dir_q        <= dir_d;
      andar_q      <= andar_d;
      cnt_viagem_q <= cnt_viagem_d;
      cnt_porta_q  <= cnt_porta_d;
    end
  end

  // Call latch runs every clock; clearing the served floor beats a new set there
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q | chamada) & ~limpa;
    end
  end

  assign andar_atual  = andar_q;
  assign subindo      = (estado_q == MOVENDO) && (dir_q == SOBE);
  assign descendo     = (estado_q == MOVENDO) && (dir_q == DESCE);
  assign porta_aberta = (estado_q == PORTA);
  assign pendentes    = pend_q;

endmodule

// File: tb/tb_controle_elevador_chamadas.sv
// Scoreboard bench for controle_elevador_chamadas: each stimulus tick queues
// the expected outputs, and a monitor compares them after the tick edge.
module tb_controle_elevador_chamadas;

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tick     = 1'b0;
  logic [3:0] chamada  = '0;
  logic [1:0] andar_atual;
  logic       subindo, descendo, porta_aberta;
  logic [3:0] pendentes;

  controle_elevador_chamadas #(
    .N_ANDARES (4),
    .T_VIAGEM  (2),
    .T_PORTA   (3)
  ) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .tick         (tick),
    .chamada      (chamada),
    .andar_atual  (andar_atual),
    .subindo      (subindo),
    .descendo     (descendo),
    .porta_aberta (porta_aberta),
    .pendentes    (pendentes)
  );

  always #5 clock_in = ~clock_in;

  // expected = {andar[1:0], subindo, descendo, porta_aberta, pendentes[3:0]}
  logic [8:0]  exp_q[$];
  string       nome_q[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  string       cenario  = "reset";
  int unsigned passo    = 0;
  event        chk_now;

  task automatic compara();
    logic [8:0] esp, atual;
    string      nm;
    esp   = exp_q.pop_front();
    nm    = nome_q.pop_front();
    atual = {andar_atual, subindo, descendo, porta_aberta, pendentes};
    n_checks++;
    if (atual !== esp) begin
      n_err++;
      $display("FAIL %s: got andar=%0d sub=%b desc=%b porta=%b pend=%b, expected andar=%0d sub=%b desc=%b porta=%b pend=%b",
               nm, atual[8:7], atual[6], atual[5], atual[4], atual[3:0],
               esp[8:7], esp[6], esp[5], esp[4], esp[3:0]);
    end
  endtask

  // Monitor: the DUT presents a new result after every tick edge
  initial forever begin
    @(posedge clock_in);
    if (tick && exp_q.size() > 0) begin
      #1;
      compara();
    end
  end

  // Monitor for checks not tied to a clock edge (asynchronous reset)
  initial forever begin
    @(chk_now);
    if (exp_q.size() > 0) compara();
  end

  task automatic novo(input string nome);
    cenario = nome;
    passo   = 0;
  endtask

  task automatic empilha(input logic [1:0] a, input logic [2:0] sdp, input logic [3:0] p);
    passo++;
    exp_q.push_back({a, sdp, p});
    nome_q.push_back($sformatf("%s#%0d", cenario, passo));
  endtask

  // One tick period (4 clocks) with optional call pulse on the tick cycle
  task automatic tk(input logic [3:0] ch, input logic [1:0] a, input logic [2:0] sdp, input logic [3:0] p);
    empilha(a, sdp, p);
    @(negedge clock_in);
    tick    = 1'b1;
    chamada = ch;
    @(negedge clock_in);
    tick    = 1'b0;
    chamada = '0;
    repeat (2) @(negedge clock_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // sdp codes: 100 = subindo, 010 = descendo, 001 = porta_aberta
  initial begin
    // Reset state while reset_n is held low
    #2;
    empilha(2'd0, 3'b000, 4'b0000);
    -> chk_now;
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;

    novo("idle");
    for (int i = 0; i < 20; i++) tk(4'b0000, 2'd0, 3'b000, 4'b0000);

    novo("sobe_3");
    tk(4'b1000, 2'd0, 3'b000, 4'b1000);
    tk(4'b0000, 2'd0, 3'b100, 4'b1000);
    tk(4'b0000, 2'd0, 3'b100, 4'b1000);
    tk(4'b0000, 2'd1, 3'b100, 4'b1000);
    tk(4'b0000, 2'd1, 3'b100, 4'b1000);
    tk(4'b0000, 2'd2, 3'b100, 4'b1000);
    tk(4'b0000, 2'd2, 3'b100, 4'b1000);
    tk(4'b0000, 2'd3, 3'b001, 4'b0000);
    tk(4'b0000, 2'd3, 3'b001, 4'b0000);
    tk(4'b0000, 2'd3, 3'b001, 4'b0000);
    tk(4'b0000, 2'd3, 3'b000, 4'b0000);
    tk(4'b0000, 2'd3, 3'b000, 4'b0000);

    novo("desce_2_0");
    tk(4'b0001, 2'd3, 3'b000, 4'b0001);
    tk(4'b0100, 2'd3, 3'b010, 4'b0101);
    tk(4'b0000, 2'd3, 3'b010, 4'b0101);
    tk(4'b0000, 2'd2, 3'b001, 4'b0001);
    tk(4'b0000, 2'd2, 3'b001, 4'b0001);
    tk(4'b0000, 2'd2, 3'b001, 4'b0001);
    tk(4'b0000, 2'd2, 3'b010, 4'b0001);
    tk(4'b0000, 2'd2, 3'b010, 4'b0001);
    tk(4'b0000, 2'd1, 3'b010, 4'b0001);
    tk(4'b0000, 2'd1, 3'b010, 4'b0001);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b000, 4'b0000);

    novo("porta_retida");
    tk(4'b0100, 2'd0, 3'b000, 4'b0100);
    tk(4'b0000, 2'd0, 3'b100, 4'b0100);
    tk(4'b0000, 2'd0, 3'b100, 4'b0100);
    tk(4'b0000, 2'd1, 3'b100, 4'b0100);
    tk(4'b0000, 2'd1, 3'b100, 4'b0100);
    tk(4'b0000, 2'd2, 3'b001, 4'b0000);
    tk(4'b0000, 2'd2, 3'b001, 4'b0000);
    tk(4'b0100, 2'd2, 3'b001, 4'b0000);
    tk(4'b0000, 2'd2, 3'b001, 4'b0000);
    tk(4'b0000, 2'd2, 3'b001, 4'b0000);
    tk(4'b0000, 2'd2, 3'b000, 4'b0000);

    novo("volta_0");
    tk(4'b0001, 2'd2, 3'b000, 4'b0001);
    tk(4'b0000, 2'd2, 3'b010, 4'b0001);
    tk(4'b0000, 2'd2, 3'b010, 4'b0001);
    tk(4'b0000, 2'd1, 3'b010, 4'b0001);
    tk(4'b0000, 2'd1, 3'b010, 4'b0001);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b000, 4'b0000);

    novo("scan_reverte");
    tk(4'b1000, 2'd0, 3'b000, 4'b1000);
    tk(4'b0000, 2'd0, 3'b100, 4'b1000);
    tk(4'b0000, 2'd0, 3'b100, 4'b1000);
    tk(4'b0000, 2'd1, 3'b100, 4'b1000);
    tk(4'b0001, 2'd1, 3'b100, 4'b1001);
    tk(4'b0000, 2'd2, 3'b100, 4'b1001);
    tk(4'b0000, 2'd2, 3'b100, 4'b1001);
    tk(4'b0000, 2'd3, 3'b001, 4'b0001);
    tk(4'b0000, 2'd3, 3'b001, 4'b0001);
    tk(4'b0000, 2'd3, 3'b001, 4'b0001);
    tk(4'b0000, 2'd3, 3'b010, 4'b0001);
    tk(4'b0000, 2'd3, 3'b010, 4'b0001);
    tk(4'b0000, 2'd2, 3'b010, 4'b0001);
    tk(4'b0000, 2'd2, 3'b010, 4'b0001);
    tk(4'b0000, 2'd1, 3'b010, 4'b0001);
    tk(4'b0000, 2'd1, 3'b010, 4'b0001);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b000, 4'b0000);

    novo("reset_em_movimento");
    tk(4'b1000, 2'd0, 3'b000, 4'b1000);
    tk(4'b0000, 2'd0, 3'b100, 4'b1000);
    tk(4'b0000, 2'd0, 3'b100, 4'b1000);
    tk(4'b0000, 2'd1, 3'b100, 4'b1000);
    tk(4'b0000, 2'd1, 3'b100, 4'b1000);
    @(negedge clock_in);
    reset_n = 1'b0;
    #1;
    empilha(2'd0, 3'b000, 4'b0000);
    -> chk_now;
    repeat (3) @(negedge clock_in);
    reset_n = 1'b1;

    novo("pos_reset");
    tk(4'b0000, 2'd0, 3'b000, 4'b0000);
    tk(4'b0001, 2'd0, 3'b000, 4'b0001);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b001, 4'b0000);
    tk(4'b0000, 2'd0, 3'b000, 4'b0000);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clock_in);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expected results never checked, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
